// File: rtl/instr_sequencer.sv
// Multi-cycle FETCH/DECODE/EXEC/MEM/WB phase sequencer for the KGP-RISC datapath.
// Optional feature macro INSTR_SEQ_PERF_EN adds perf_retired/perf_stall counters.
module instr_sequencer #(
  parameter int MEM_TIMEOUT = 16,
  parameter int STATE_W     = 3
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               run,
  input  logic               mem_read,
  input  logic               mem_write,
  input  logic               reg_write,
  input  logic               branch,
  input  logic               push,
  input  logic               pop,
  input  logic               branch_taken,
  input  logic               imem_ready,
  input  logic               dmem_ready,
  output logic               imem_req,
  output logic               ir_load,
  output logic               dmem_req,
  output logic               dmem_we,
  output logic               reg_we,
  output logic               pc_we,
  output logic               pc_sel_branch,
  output logic               sp_dec,
  output logic               sp_inc,
  output logic               busy,
  output logic               err,
  output logic               retired,
`ifdef INSTR_SEQ_PERF_EN
  output logic [31:0]        perf_retired,
  output logic [31:0]        perf_stall,
`endif
  output logic [STATE_W-1:0] state
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_FETCH  = 3'd1,
    S_DECODE = 3'd2,
    S_EXEC   = 3'd3,
    S_MEM    = 3'd4,
    S_WB     = 3'd5,
    S_ERROR  = 3'd7
  } state_t;

  typedef struct packed {
    logic mem_read;
    logic mem_write;
    logic reg_write;
    logic branch;
    logic push;
    logic pop;
  } ctrl_t;

  localparam int CNT_W = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT) : 1;
  localparam logic [CNT_W-1:0] TMO_LAST = CNT_W'((MEM_TIMEOUT > 0) ? MEM_TIMEOUT - 1 : 0);

  state_t           state_q, state_d;
  ctrl_t            ctrl_q, ctrl_in;
  logic             take_br_q;
  logic [CNT_W-1:0] tmo_cnt_q;
  logic             waiting, timeout_hit, illegal, needs_mem;

  assign ctrl_in     = {mem_read, mem_write, reg_write, branch, push, pop};
  assign waiting     = (state_q == S_FETCH && !imem_ready) || (state_q == S_MEM && !dmem_ready);
  assign timeout_hit = (MEM_TIMEOUT != 0) && waiting && (tmo_cnt_q == TMO_LAST);
  // Checked on the live decode bus: these are exactly the values latched at this edge.
  assign illegal     = (push && pop) || (mem_read && mem_write);
  assign needs_mem   = ctrl_q.mem_read | ctrl_q.mem_write | ctrl_q.push | ctrl_q.pop;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      ctrl_q    <= '0;
      take_br_q <= 1'b0;
      tmo_cnt_q <= '0;
    end else begin
      state_q <= state_d;
      if (state_q == S_DECODE) ctrl_q <= ctrl_in;
      if (state_q == S_EXEC) take_br_q <= ctrl_q.branch & branch_taken;
      // Only FETCH/MEM can wait, and both are entered from non-waiting states,
      // so clearing whenever we are not waiting is the same as clearing on entry.
      tmo_cnt_q <= waiting ? tmo_cnt_q + CNT_W'(1) : '0;
    end
  end

  // NOTE: every output and state_d gets a default before the case statement,
  // so no path through this block can leave a value unassigned (no latches).
  always_comb begin
    state_d       = state_q;
    imem_req      = 1'b0;
    ir_load       = 1'b0;
    dmem_req      = 1'b0;
    dmem_we       = 1'b0;
    reg_we        = 1'b0;
    pc_we         = 1'b0;
    pc_sel_branch = 1'b0;
    sp_dec        = 1'b0;
    sp_inc        = 1'b0;
    retired       = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        if (run) state_d = S_FETCH;
      end
      S_FETCH: begin
        imem_req = 1'b1;
        if (imem_ready) begin
          ir_load = 1'b1;
          state_d = S_DECODE;
        end else if (timeout_hit) begin
          state_d = S_ERROR;
        end
      end
      S_DECODE: begin
        state_d = illegal ? S_ERROR : S_EXEC;
      end
      S_EXEC: begin
        sp_dec  = ctrl_q.push;
        state_d = needs_mem ? S_MEM : S_WB;
      end
      S_MEM: begin
        dmem_req = 1'b1;
        dmem_we  = ctrl_q.mem_write | ctrl_q.push;
        if (dmem_ready) state_d = S_WB;
        else if (timeout_hit) state_d = S_ERROR;
      end
      S_WB: begin
        reg_we        = ctrl_q.reg_write;
        sp_inc        = ctrl_q.pop;
        pc_we         = 1'b1;
        pc_sel_branch = take_br_q;
        retired       = 1'b1;
        state_d       = run ? S_FETCH : S_IDLE;
      end
      S_ERROR: begin
        state_d = S_ERROR;
      end
      default: begin
        state_d = S_ERROR;
      end
    endcase
  end

  assign busy  = (state_q != S_IDLE) && (state_q != S_ERROR);
  assign err   = (state_q == S_ERROR);
  assign state = STATE_W'(state_q);

`ifdef INSTR_SEQ_PERF_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      perf_retired <= '0;
      perf_stall   <= '0;
    end else if (state_q != S_ERROR) begin
      if (retired) perf_retired <= perf_retired + 32'd1;
      if (waiting) perf_stall   <= perf_stall + 32'd1;
    end
  end
`endif

endmodule
